// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
   typedef enum logic {RUN, HALT} state_t;
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: 2-entry synchronous FIFO with flush, used for buffered instructions and issued addresses
module ifu_fifo #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         empty,
   output logic         full
);
   logic [W-1:0] mem [2];
   logic rp, wp, do_pop, do_push;
   assign empty = count == 2'd0;
   assign full = count == 2'd2;
   assign dout = mem[rp];
   assign do_pop = pop & ~empty;
   // a full FIFO may accept a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rp <= 1'b0;
         wp <= 1'b0;
         count <= 2'd0;
      end else if (flush) begin
         rp <= 1'b0;
         wp <= 1'b0;
         count <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp <= ~wp;
         end
         if (do_pop) rp <= ~rp;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit - PC, credit-limited fetch requests, redirect/halt handling
module ifu import ifu_pkg::*; #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        halted
);
   state_t state, state_nxt;
   logic [31:0] pc, rsp_pc;
   logic [63:0] fdout;
   logic [1:0] outstanding, drop_cnt, out_nxt, fcnt;
   logic live, fire, rsp_ok, drop, pop, fempty, ffull, aempty, afull;
   logic unused_full;
   assign unused_full = ffull & afull;
   assign fire = imem_req_valid & imem_req_ready;
   assign rsp_ok = imem_rsp_valid & ~aempty;
   assign drop = rsp_ok & (drop_cnt != 2'd0);
   assign pop = inst_valid & inst_ready;
   // a head instruction leaving this cycle already frees its credit
   assign imem_req_valid = live & (state == RUN) & ({1'b0, outstanding} + {1'b0, fcnt} - {2'b00, pop} < 3'd2);
   assign imem_req_addr = pc;
   assign inst_valid = ~fempty;
   assign {inst, inst_pc} = inst_valid ? fdout : '0;
   assign halted = (state == HALT) & aempty;
   assign out_nxt = outstanding + {1'b0, fire} - {1'b0, rsp_ok};
   always_comb begin
      state_nxt = (state == RUN && halt) ? HALT : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         live <= 1'b0;
         pc <= RESET_PC;
         drop_cnt <= 2'd0;
      end else begin
         state <= state_nxt;
         live <= 1'b1;
         pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : fire ? pc + 32'd4 : pc;
         // everything still in flight after a redirect belongs to the old path
         drop_cnt <= redirect_valid ? out_nxt : drop_cnt - {1'b0, drop};
      end
   end
   ifu_fifo #(.W(64)) u_ibuf (
      .clk(clk), .rst_n(rst_n), .push(rsp_ok & ~drop & ~redirect_valid), .pop(pop),
      .flush(redirect_valid), .din({imem_rsp_data, rsp_pc}), .dout(fdout),
      .count(fcnt), .empty(fempty), .full(ffull)
   );
   // issued-address queue; its occupancy is the outstanding request count
   ifu_fifo #(.W(32)) u_aq (
      .clk(clk), .rst_n(rst_n), .push(fire), .pop(rsp_ok), .flush(1'b0),
      .din(pc), .dout(rsp_pc), .count(outstanding), .empty(aempty), .full(afull)
   );
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized scoreboard bench for ifu against a program-order fetch model
module tb_ifu;
   localparam logic [31:0] RPC = 32'h8000_0000;
   logic clk, rst_n;
   logic imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic inst_valid, inst_ready, redirect_valid, halt, halted;
   logic [31:0] inst, inst_pc, redirect_pc;

   ifu #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0, lat = 1, outs_m = 0, npop = 0, idle = 0;
   bit hst_m = 1'b0;
   int due_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] exp_q[$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // expected program-order stream from a fetch target
   task automatic set_path(input logic [31:0] p);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back({p[31:2], 2'b00} + 32'(4 * i));
   endtask

   // memory: in-order responses, at most one per cycle, lat cycles after the fire
   always @(posedge clk) begin
      int d;
      logic [31:0] a;
      #1;
      cyc++;
      if (!rst_n) begin
         due_q.delete();
         addr_q.delete();
         imem_rsp_valid = 1'b0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
         d = due_q.pop_front();
         a = addr_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data = memf(a);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = $urandom;
      end
   end

   // environment: records fires, tracks outstanding/halt, checks halted and request rules
   always @(negedge clk) begin
      logic f;
      int d;
      if (rst_n) begin
         f = imem_req_valid & imem_req_ready;
         if (imem_req_valid) chk("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
         chk("halted", halted, hst_m && outs_m == 0);
         if (hst_m) chk("req_in_halt", imem_req_valid, 0);
         if (f) begin
            d = cyc + lat;
            if (due_q.size() > 0 && due_q[$] >= d) d = due_q[$] + 1;
            due_q.push_back(d);
            addr_q.push_back(imem_req_addr);
         end
         outs_m = outs_m + int'(f) - int'(imem_rsp_valid && outs_m > 0);
         if (halt) hst_m = 1'b1;
      end else begin
         outs_m = 0;
         hst_m = 1'b0;
      end
   end

   // monitor: pops the scoreboard on each decode handshake, then applies any redirect
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n) begin
         if (inst_valid && inst_ready) begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e);
            chk("inst", inst, memf(e));
            exp_q.push_back(e + 32'd16);
            npop++;
            idle = 0;
         end else if (inst_ready && imem_req_ready && !hst_m) begin
            idle++;
            if (idle > 20) begin
               total++;
               bad++;
               $display("FAIL liveness: no instruction for %0d ready cycles (cycle %0d)", idle, cyc);
               idle = 0;
            end
         end
         if (redirect_valid) set_path(redirect_pc);
      end else idle = 0;
   end

   task automatic go();
      @(posedge clk);
      #2;
      redirect_valid = 1'b0;
   endtask

   task automatic release_rst();
      go();
      go();
      rst_n = 1'b1;
      set_path(RPC);
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      lat = 1;
   endtask

   task automatic areset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      halt = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_halted", halted, 0);
   endtask

   task automatic wait_inst(input string n, input logic [31:0] p);
      int k;
      k = 0;
      do begin
         go();
         k++;
      end while (!inst_valid && k < 20);
      chk(n, inst_pc, p);
   endtask

   task automatic quiesce();
      int n;
      n = 0;
      do begin
         go();
         imem_req_ready = 1'b0;
         inst_ready = 1'b1;
         n++;
      end while ((outs_m != 0 || inst_valid) && n < 30);
      chk("quiesce", n < 30, 1);
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         go();
         imem_req_ready = $urandom_range(0, 9) < 7;
         inst_ready = $urandom_range(0, 9) < 7;
         lat = $urandom_range(1, 3);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = RPC + 32'($urandom_range(0, 4095));
         end
      end
   endtask

   initial begin
      int n0;
      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_valid", imem_req_valid, 0);
      chk("reset_inst_valid", inst_valid, 0);
      chk("reset_inst", inst, 0);
      chk("reset_inst_pc", inst_pc, 0);
      chk("reset_halted", halted, 0);

      release_rst();
      @(negedge clk);
      chk("req_in_release_cycle", imem_req_valid, 0);
      for (int i = 0; i < 3; i++) begin
         go();
         @(negedge clk);
         chk("fetch_valid", imem_req_valid, 1);
         chk("fetch_addr", imem_req_addr, RPC + 32'(4 * i));
         chk("inst_latency", inst_valid, i == 2);
      end
      for (int i = 0; i < 3; i++) begin
         go();
         @(negedge clk);
         chk("tput_inst_valid", inst_valid, 1);
         chk("tput_req_valid", imem_req_valid, 1);
      end

      go();
      inst_ready = 1'b0;
      repeat (4) go();
      @(negedge clk);
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_inst_valid", inst_valid, 1);
      chk("stall_outstanding", outs_m, 0);
      go();
      inst_ready = 1'b1;
      repeat (5) go();

      rand_run(400);

      quiesce();
      go();
      lat = 3;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      go();
      go();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_1002;
      @(negedge clk);
      chk("redir_outstanding", outs_m, 2);
      go();
      imem_req_ready = 1'b1;
      @(negedge clk);
      chk("redir_inst_valid", inst_valid, 0);
      chk("redir_addr", imem_req_addr, 32'h8000_1000);
      wait_inst("redir_first_pc", 32'h8000_1000);
      repeat (4) go();

      quiesce();
      go();
      lat = 1;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      repeat (4) go();
      go();
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_2000;
      @(negedge clk);
      chk("same_fire", imem_req_valid, 1);
      chk("same_outstanding", outs_m, 1);
      wait_inst("same_first_pc", 32'h8000_2000);
      repeat (6) go();

      quiesce();
      go();
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'hDEAD_BEEF;
      inst_ready = 1'b0;
      go();
      @(negedge clk);
      chk("spur_no_push", inst_valid, 0);
      go();
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      chk("spur_credit", imem_req_valid, 1);
      wait_inst("spur_next_pc", exp_q[0]);
      repeat (3) go();

      quiesce();
      go();
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_3000;
      go();
      lat = 3;
      imem_req_ready = 1'b1;
      inst_ready = 1'b0;
      go();
      imem_req_ready = 1'b0;
      repeat (3) go();
      go();
      imem_req_ready = 1'b1;
      go();
      imem_req_ready = 1'b0;
      halt = 1'b1;
      n0 = npop;
      @(negedge clk);
      chk("halt_setup_outs", outs_m, 1);
      chk("halt_setup_valid", inst_valid, 1);
      for (int i = 0; i < 14; i++) begin
         go();
         imem_req_ready = 1'b1;
         inst_ready = i >= 6;
      end
      @(negedge clk);
      chk("halt_delivered", npop - n0, 2);
      chk("halt_drained", inst_valid, 0);
      chk("halted_end", halted, 1);

      areset();
      release_rst();
      repeat (6) go();
      areset();
      release_rst();
      rand_run(400);
      quiesce();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
      $fatal(1);
   end
endmodule
